// File: rtl/mem_pkg.sv
// Shared constants for the memory responder: response owner encoding,
// default geometry and response-stage field widths.
package mem_pkg;

   localparam logic OWNER_IF = 1'b0;
   localparam logic OWNER_D  = 1'b1;

   localparam int unsigned MEM_ADDR_W = 15;
   localparam int unsigned MEM_DATA_W = 16;

   localparam int unsigned RSP_VALID_W = 1;
   localparam int unsigned RSP_OWNER_W = 1;
   localparam int unsigned RSP_WE_W    = 1;

   localparam int unsigned MIN_LATENCY = 1;
   localparam int unsigned MAX_LATENCY = 4;

endpackage

// File: rtl/mem_rsp_pipe.sv
// Fixed-depth response pipeline carrying {valid, owner, we, data}.
// Only the valid bits are cleared by reset; payload follows them.
module mem_rsp_pipe
   import mem_pkg::*;
#(
   parameter int unsigned LATENCY = 2,
   parameter int unsigned DATA_W  = MEM_DATA_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_valid,
   input  logic              i_owner,
   input  logic              i_we,
   input  logic [DATA_W-1:0] i_data,
   output logic              o_valid,
   output logic              o_owner,
   output logic              o_we,
   output logic [DATA_W-1:0] o_data
);

   logic [LATENCY-1:0]                r_valid;
   logic [RSP_OWNER_W-1:0]            r_owner [LATENCY];
   logic [RSP_WE_W-1:0]               r_we    [LATENCY];
   logic [DATA_W-1:0]                 r_data  [LATENCY];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= '0;
      end else begin
         r_valid[0] <= i_valid;
         for (int i = 1; i < int'(LATENCY); i++) begin
            r_valid[i] <= r_valid[i-1];
         end
      end
   end

   // Payload shifts unconditionally; it is meaningless unless the matching valid is set.
   always_ff @(posedge clk) begin
      r_owner[0] <= i_owner;
      r_we[0]    <= i_we;
      r_data[0]  <= i_data;
      for (int i = 1; i < int'(LATENCY); i++) begin
         r_owner[i] <= r_owner[i-1];
         r_we[i]    <= r_we[i-1];
         r_data[i]  <= r_data[i-1];
      end
   end

   assign o_valid = r_valid[LATENCY-1];
   assign o_owner = r_owner[LATENCY-1];
   assign o_we    = r_we[LATENCY-1];
   assign o_data  = r_data[LATENCY-1];

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: round-robin arbitration of fetch and data requests
// onto one single-ported word array, with a fixed-latency in-order response pipe.
module mem_responder
   import mem_pkg::*;
#(
   parameter int unsigned ADDR_W  = MEM_ADDR_W,
   parameter int unsigned DATA_W  = MEM_DATA_W,
   parameter int unsigned LATENCY = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              if_req_valid,
   output logic              if_req_ready,
   input  logic [ADDR_W-1:0] if_req_addr,
   output logic              if_rsp_valid,
   output logic [DATA_W-1:0] if_rsp_data,
   input  logic              d_req_valid,
   output logic              d_req_ready,
   input  logic              d_req_we,
   input  logic [ADDR_W-1:0] d_req_addr,
   input  logic [DATA_W-1:0] d_req_wdata,
   output logic              d_rsp_valid,
   output logic [DATA_W-1:0] d_rsp_data,
   output logic              d_rsp_we
);

   localparam int unsigned DEPTH = 2 ** ADDR_W;

   generate
      if (LATENCY < MIN_LATENCY || LATENCY > MAX_LATENCY) begin : g_bad_latency
         $error("mem_responder: LATENCY must be in 1..4");
      end
   endgenerate

   logic              r_prio_d;
   logic              w_contested;
   logic              w_grant_if;
   logic              w_grant_d;
   logic              w_store;
   logic [ADDR_W-1:0] w_addr;
   logic [DATA_W-1:0] w_rd_data;
   logic [DATA_W-1:0] w_pipe_data;
   logic              w_p_valid;
   logic              w_p_owner;
   logic              w_p_we;
   logic [DATA_W-1:0] w_p_data;

   logic [DATA_W-1:0] r_mem [DEPTH];

   // Grants are forced low while in reset so no access slips in during it.
   assign w_contested = if_req_valid & d_req_valid;
   assign w_grant_d   = rst_n & d_req_valid & (~if_req_valid | r_prio_d);
   assign w_grant_if  = rst_n & if_req_valid & ~w_grant_d;
   assign w_store     = w_grant_d & d_req_we;

   assign if_req_ready = w_grant_if;
   assign d_req_ready  = w_grant_d;

   // Priority moves to whichever side lost a contested cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_prio_d <= 1'b0;
      end else if (w_contested) begin
         r_prio_d <= w_grant_if;
      end
   end

   assign w_addr      = w_grant_d ? d_req_addr : if_req_addr;
   assign w_rd_data   = r_mem[w_addr];
   assign w_pipe_data = w_store ? '0 : w_rd_data;

   // Storage is deliberately not reset so granted stores survive a reset.
   always_ff @(posedge clk) begin
      if (w_store) begin
         r_mem[d_req_addr] <= d_req_wdata;
      end
   end

   mem_rsp_pipe #(
      .LATENCY (LATENCY),
      .DATA_W  (DATA_W)
   ) u_rsp_pipe (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_valid (w_grant_if | w_grant_d),
      .i_owner (w_grant_d ? OWNER_D : OWNER_IF),
      .i_we    (w_store),
      .i_data  (w_pipe_data),
      .o_valid (w_p_valid),
      .o_owner (w_p_owner),
      .o_we    (w_p_we),
      .o_data  (w_p_data)
   );

   // Demux by owner; data and we are gated so they read 0 whenever not valid.
   assign if_rsp_valid = w_p_valid & (w_p_owner == OWNER_IF);
   assign d_rsp_valid  = w_p_valid & (w_p_owner == OWNER_D);
   assign if_rsp_data  = if_rsp_valid ? w_p_data : '0;
   assign d_rsp_data   = d_rsp_valid ? w_p_data : '0;
   assign d_rsp_we     = d_rsp_valid & w_p_we;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed traffic against a
// transaction-level model (sparse memory map + expected-response queue).
module tb_mem_responder;

   localparam int unsigned AW  = 15;
   localparam int unsigned DW  = 16;
   localparam int unsigned LAT = 2;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          if_req_valid, if_req_ready, if_rsp_valid;
   logic [AW-1:0] if_req_addr;
   logic [DW-1:0] if_rsp_data;
   logic          d_req_valid, d_req_ready, d_req_we, d_rsp_valid, d_rsp_we;
   logic [AW-1:0] d_req_addr;
   logic [DW-1:0] d_req_wdata, d_rsp_data;

   mem_responder #(.ADDR_W(AW), .DATA_W(DW), .LATENCY(LAT)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .if_req_valid (if_req_valid),
      .if_req_ready (if_req_ready),
      .if_req_addr  (if_req_addr),
      .if_rsp_valid (if_rsp_valid),
      .if_rsp_data  (if_rsp_data),
      .d_req_valid  (d_req_valid),
      .d_req_ready  (d_req_ready),
      .d_req_we     (d_req_we),
      .d_req_addr   (d_req_addr),
      .d_req_wdata  (d_req_wdata),
      .d_rsp_valid  (d_rsp_valid),
      .d_rsp_data   (d_rsp_data),
      .d_rsp_we     (d_rsp_we)
   );

   always #5 clk = ~clk;

   int pc = 0;
   always @(posedge clk) pc <= pc + 1;

   typedef struct { int due; logic owner; logic we; logic [DW-1:0] data; bit known; } exp_t;
   typedef struct { int pc; logic owner; logic we; logic [DW-1:0] data; } obs_t;

   exp_t          exp_q[$];
   obs_t          obs_q[$];
   logic [1:0]    gnt_q[$];
   logic [DW-1:0] mm [int];
   bit            m_prio_d;
   int            n_tests = 0;
   int            n_fail  = 0;
   int            s, g, h, h_st;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic int obs_pc(input int idx);
      return (idx < obs_q.size()) ? obs_q[idx].pc : -1;
   endfunction

   task automatic chk_obs(input string nm, input int idx, input logic owner,
                          input logic we, input logic [DW-1:0] data);
      if (idx >= obs_q.size()) begin
         n_tests++;
         n_fail++;
         $display("FAIL %s: response #%0d missing, got %0d responses", nm, idx, obs_q.size());
      end else begin
         chk({nm, "_owner"}, 32'(obs_q[idx].owner), 32'(owner));
         chk({nm, "_we"},    32'(obs_q[idx].we),    32'(we));
         chk({nm, "_data"},  32'(obs_q[idx].data),  32'(data));
      end
   endtask

   // One request cycle: drive, check readies against the model, commit model at the edge.
   task automatic step(input logic ifv, input logic [AW-1:0] ifa, input logic dv,
                       input logic dwe, input logic [AW-1:0] da, input logic [DW-1:0] dwd,
                       output int hs);
      bit   gi, gd;
      exp_t e;
      #1;
      if_req_valid = ifv; if_req_addr = ifa;
      d_req_valid  = dv;  d_req_we = dwe; d_req_addr = da; d_req_wdata = dwd;
      gd = dv && (!ifv || m_prio_d);
      gi = ifv && !gd;
      #1;
      chk("if_req_ready", 32'(if_req_ready), 32'(gi));
      chk("d_req_ready",  32'(d_req_ready),  32'(gd));
      gnt_q.push_back({if_req_ready, d_req_ready});
      @(posedge clk);
      #1;
      hs = pc - 1;
      if (ifv && dv) m_prio_d = gi;
      if (gi) begin
         e.due = hs + int'(LAT); e.owner = 1'b0; e.we = 1'b0;
         e.known = mm.exists(int'(ifa));
         e.data  = e.known ? mm[int'(ifa)] : '0;
         exp_q.push_back(e);
      end
      if (gd) begin
         e.due = hs + int'(LAT); e.owner = 1'b1; e.we = dwe;
         if (dwe) begin
            mm[int'(da)] = dwd;
            e.known = 1'b1; e.data = '0;
         end else begin
            e.known = mm.exists(int'(da));
            e.data  = e.known ? mm[int'(da)] : '0;
         end
         exp_q.push_back(e);
      end
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      int hh;
      for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0, '0, '0, hh);
   endtask

   task automatic do_reset(input int n);
      #1;
      rst_n = 1'b0;
      if_req_valid = 1'b0;
      d_req_valid  = 1'b0;
      exp_q.delete();
      m_prio_d = 1'b0;
      repeat (n) @(negedge clk);
      #1 rst_n = 1'b1;
   endtask

   // Response checker: every negedge, compare outputs to the model's due response.
   always @(negedge clk) begin
      exp_t e;
      bit   have;
      obs_t o;
      if (!rst_n) begin
         chk("rst_if_req_ready", 32'(if_req_ready), 32'(0));
         chk("rst_d_req_ready",  32'(d_req_ready),  32'(0));
         chk("rst_if_rsp_valid", 32'(if_rsp_valid), 32'(0));
         chk("rst_d_rsp_valid",  32'(d_rsp_valid),  32'(0));
         chk("rst_d_rsp_we",     32'(d_rsp_we),     32'(0));
      end else begin
         have = 1'b0;
         if (exp_q.size() > 0 && exp_q[0].due <= pc) begin
            e = exp_q.pop_front();
            have = 1'b1;
            if (e.due < pc) chk("rsp_timing", 32'(pc), 32'(e.due));
         end
         chk("if_rsp_valid", 32'(if_rsp_valid), 32'(have && e.owner == 1'b0));
         chk("d_rsp_valid",  32'(d_rsp_valid),  32'(have && e.owner == 1'b1));
         if (have && e.owner == 1'b1) chk("d_rsp_we", 32'(d_rsp_we), 32'(e.we));
         if (have && e.known && e.owner == 1'b0) chk("if_rsp_data", 32'(if_rsp_data), 32'(e.data));
         if (have && e.known && e.owner == 1'b1) chk("d_rsp_data",  32'(d_rsp_data),  32'(e.data));
         if (if_rsp_valid) begin
            o.pc = pc; o.owner = 1'b0; o.we = 1'b0; o.data = if_rsp_data; obs_q.push_back(o);
         end
         if (d_rsp_valid) begin
            o.pc = pc; o.owner = 1'b1; o.we = d_rsp_we; o.data = d_rsp_data; obs_q.push_back(o);
         end
      end
   end

   initial begin
      rst_n = 1'b0;
      if_req_valid = 1'b1; if_req_addr = '0;
      d_req_valid  = 1'b1; d_req_we = 1'b0; d_req_addr = '0; d_req_wdata = '0;
      m_prio_d = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      rst_n = 1'b1;
      if_req_valid = 1'b0;
      d_req_valid  = 1'b0;

      // Preload words 0..7 and the top word.
      for (int i = 0; i < 8; i++)
         step(1'b0, '0, 1'b1, 1'b1, AW'(i), 16'h1000 + DW'(i) * 16'h0111, h);
      step(1'b0, '0, 1'b1, 1'b1, 15'h7FFF, 16'hA5A5, h);
      idle(LAT + 1);
      chk("model_word4", 32'(mm[4]), 32'h1444);

      // Store then load at the same address.
      s = obs_q.size();
      step(1'b0, '0, 1'b1, 1'b1, 15'h0010, 16'hBEEF, h_st);
      step(1'b0, '0, 1'b1, 1'b0, 15'h0010, 16'h0000, h);
      idle(LAT + 1);
      chk_obs("st_ack", s, 1'b1, 1'b1, 16'h0000);
      chk_obs("ld_after_st", s + 1, 1'b1, 1'b0, 16'hBEEF);
      chk("st_ack_time", 32'(obs_pc(s)), 32'(h_st + int'(LAT)));
      chk("ld_time", 32'(obs_pc(s + 1)), 32'(h_st + int'(LAT) + 1));

      // Contention: first contested grant after reset goes to fetch; d changes addr while waiting.
      s = obs_q.size();
      g = gnt_q.size();
      step(1'b1, 15'd0, 1'b1, 1'b0, 15'd7, '0, h_st);
      step(1'b1, 15'd1, 1'b1, 1'b0, 15'd4, '0, h);
      step(1'b1, 15'd1, 1'b1, 1'b0, 15'd5, '0, h);
      step(1'b1, 15'd2, 1'b1, 1'b0, 15'd5, '0, h);
      idle(LAT + 1);
      chk("gnt0", 32'(gnt_q[g]),     32'(2'b10));
      chk("gnt1", 32'(gnt_q[g + 1]), 32'(2'b01));
      chk("gnt2", 32'(gnt_q[g + 2]), 32'(2'b10));
      chk("gnt3", 32'(gnt_q[g + 3]), 32'(2'b01));
      chk_obs("cont0", s,     1'b0, 1'b0, 16'h1000);
      chk_obs("cont1", s + 1, 1'b1, 1'b0, 16'h1444);
      chk_obs("cont2", s + 2, 1'b0, 1'b0, 16'h1111);
      chk_obs("cont3", s + 3, 1'b1, 1'b0, 16'h1555);
      chk("cont_first_time", 32'(obs_pc(s)), 32'(h_st + int'(LAT)));
      chk("cont_last_time",  32'(obs_pc(s + 3)), 32'(h_st + int'(LAT) + 3));

      // Streaming fetch 0..7, back to back.
      s = obs_q.size();
      for (int i = 0; i < 8; i++) step(1'b1, AW'(i), 1'b0, 1'b0, '0, '0, h);
      idle(LAT + 1);
      for (int i = 0; i < 8; i++) begin
         chk_obs("stream", s + i, 1'b0, 1'b0, 16'h1000 + DW'(i) * 16'h0111);
         if (i > 0) chk("stream_b2b", 32'(obs_pc(s + i)), 32'(obs_pc(s) + i));
      end

      // Address wrap: 0x7FFF + 1 lands on 0x0000, leaving 0x7FFF intact.
      s = obs_q.size();
      step(1'b0, '0, 1'b1, 1'b0, 15'h7FFF, '0, h);
      step(1'b0, '0, 1'b1, 1'b1, AW'(16'h8000), 16'h5A5A, h);
      step(1'b0, '0, 1'b1, 1'b0, 15'h0000, '0, h);
      step(1'b0, '0, 1'b1, 1'b0, 15'h7FFF, '0, h);
      idle(LAT + 1);
      chk_obs("wrap_ld_top", s,     1'b1, 1'b0, 16'hA5A5);
      chk_obs("wrap_st_ack", s + 1, 1'b1, 1'b1, 16'h0000);
      chk_obs("wrap_ld_0",   s + 2, 1'b1, 1'b0, 16'h5A5A);
      chk_obs("wrap_ld_top2", s + 3, 1'b1, 1'b0, 16'hA5A5);

      // Reset one cycle after a load grant: its response must never appear.
      step(1'b0, '0, 1'b1, 1'b0, 15'h0010, '0, h);
      s = obs_q.size();
      do_reset(3);
      idle(LAT + 2);
      chk("midflight_no_rsp", 32'(obs_q.size()), 32'(s));

      // Array contents survive the reset.
      s = obs_q.size();
      step(1'b0, '0, 1'b1, 1'b0, 15'h0010, '0, h);
      step(1'b0, '0, 1'b1, 1'b0, 15'h0000, '0, h);
      idle(LAT + 1);
      chk_obs("retain_10", s,     1'b1, 1'b0, 16'hBEEF);
      chk_obs("retain_0",  s + 1, 1'b1, 1'b0, 16'h5A5A);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
